logic_unit_pipe: RTL and testbench

//  - W-bit bitwise logic unit with 8 opcodes, optional A-negation and an internal accumulator.
//  - Two-stage registered pipeline with a valid/ready handshake on both sides; one op/cycle sustained.
//  - Zero and parity flags are produced with each result.
//  - Sits between an operand source (sequencer or testbench driver) and a result consumer in the datapath.

---
 rtl/logic_unit_pkg.sv | 38 +++
 rtl/logic_unit_core.sv | 28 ++
 rtl/logic_unit_pipe.sv | 104 ++++++++++
 tb/tb_logic_unit_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
//   OP_*     : 3-bit opcode encodings
//   lu_eval  : bitwise evaluator on LU_MAX_W bits; callers zero-extend and truncate
package logic_unit_pkg;

  // Widest operand the shared evaluator supports; instances use W <= LU_MAX_W.
  localparam int unsigned LU_MAX_W = 64;

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  // Evaluate one opcode on an already-negated A operand and B.
  function automatic logic [LU_MAX_W-1:0] lu_eval(input logic [LU_MAX_W-1:0] ax,
                                                  input logic [LU_MAX_W-1:0] b,
                                                  input logic [2:0]          op);
    logic [LU_MAX_W-1:0] r;
    r = ax;
    case (op)
      OP_NOT:  r = ~ax;
      OP_AND:  r = ax & b;
      OP_NAND: r = ~(ax & b);
      OP_OR:   r = ax | b;
      OP_NOR:  r = ~(ax | b);
      OP_XOR:  r = ax ^ b;
      OP_XNOR: r = ~(ax ^ b);
      OP_PASS: r = ax;
      default: r = ax;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Combinational W-bit operand evaluator: optional A inversion, then 8-way op select.
// Ports:
//   a_src    in  W  A source (already muxed between a and the accumulator)
//   b        in  W  operand B
//   op       in  3  opcode
//   negate   in  1  invert A source before the op
//   result_c out W  combinational result
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_src,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  input  logic         negate,
  output logic [W-1:0] result_c
);

  logic [W-1:0] ax;

  // Zero-extend into the shared evaluator and keep the low W bits.
  always_comb begin
    ax       = negate ? ~a_src : a_src;
    result_c = W'(lu_eval(LU_MAX_W'(ax), LU_MAX_W'(b), op));
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined W-bit logic unit with valid/ready on both sides,
// zero/parity flags and an internal accumulator.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake (in_ready combinational from out_ready)
//   a, b, op            operands and opcode
//   negate              invert the A source before the op
//   acc_src             take A from the accumulator instead of a
//   acc_wr              write this beat's result into the accumulator
//   acc_clr             load ACC_INIT into the accumulator (no handshake)
//   out_valid/out_ready result handshake
//   result, zero, parity registered result and flags
//   acc                 current accumulator value
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned   W        = 8,
  parameter logic [W-1:0]  ACC_INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  input  logic         negate,
  input  logic         acc_src,
  input  logic         acc_wr,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         parity,
  output logic [W-1:0] acc
);

  logic         s1_valid;
  logic [W-1:0] s1_result;
  logic         s1_adv;
  logic         s2_adv;
  logic         accept;
  logic [W-1:0] a_src;
  logic [W-1:0] core_result;

  // Stage advance: a stage may load when it is empty or its contents move on.
  always_comb begin
    s2_adv   = !out_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
    accept   = in_valid && s1_adv;
    a_src    = acc_src ? acc : a;
  end

  logic_unit_core #(.W(W)) u_core (
    .a_src    (a_src),
    .b        (b),
    .op       (op),
    .negate   (negate),
    .result_c (core_result)
  );

  // Stage 1: capture the computed result on an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_result <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (accept) s1_result <= core_result;
    end
  end

  // Stage 2: output register with flags; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      parity    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= s1_result;
        zero   <= (s1_result == '0);
        parity <= ^s1_result;
      end
    end
  end

  // Accumulator: clear wins over a same-cycle write; written at the accept edge
  // so a following acc_src beat sees the new value without a hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= ACC_INIT;
    end else if (acc_clr) begin
      acc <= ACC_INIT;
    end else if (accept && acc_wr) begin
      acc <= core_result;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (W=8, ACC_INIT=0).
module tb_logic_unit_pipe;

  localparam logic [7:0] ACC_INIT_TB = 8'h00;

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       p;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       negate;
  logic       acc_src;
  logic       acc_wr;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       zero;
  logic       parity;
  logic [7:0] acc;

  int   checks;
  int   errors;
  int   out_count;
  exp_t sb[$];
  logic [7:0] model_acc;

  logic_unit_pipe #(.W(8), .ACC_INIT(ACC_INIT_TB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .negate    (negate),
    .acc_src   (acc_src),
    .acc_wr    (acc_wr),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .parity    (parity),
    .acc       (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of one beat.
  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv,
                                 input logic [2:0] opv, input logic neg);
    logic [7:0] x;
    logic [7:0] r;
    exp_t e;
    x = neg ? ~av : av;
    case (opv)
      3'd0:    r = ~x;
      3'd1:    r = x & bv;
      3'd2:    r = ~(x & bv);
      3'd3:    r = x | bv;
      3'd4:    r = ~(x | bv);
      3'd5:    r = x ^ bv;
      3'd6:    r = ~(x ^ bv);
      default: r = x;
    endcase
    e.r = r;
    e.z = (r == 8'h00);
    e.p = ^r;
    return e;
  endfunction

  // Drive one beat (called #1 after a rising edge) and wait for its accept edge.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] top,
                      input logic tneg, input logic tsrc, input logic twr, output int waits);
    bit   accepted;
    exp_t e;
    a = ta; b = tb_v; op = top; negate = tneg; acc_src = tsrc; acc_wr = twr;
    in_valid = 1'b1;
    waits = 0;
    accepted = 0;
    for (int k = 0; k < 50 && !accepted; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e = model(tsrc ? model_acc : ta, tb_v, top, tneg);
        sb.push_back(e);
        if (acc_clr)  model_acc = ACC_INIT_TB;
        else if (twr) model_acc = e.r;
        accepted = 1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    if (!accepted) check_eq("accept_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
    acc_src = 1'b0;
    acc_wr = 1'b0;
    negate = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    @(posedge clk); #1;
    check_eq(tag, 32'(sb.size()), 32'(0));
  endtask

  // Output monitor: every transferred result is compared against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_out", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        check_eq("result", 32'(result), 32'(e.r));
        check_eq("zero", 32'(zero), 32'(e.z));
        check_eq("parity", 32'(parity), 32'(e.p));
        out_count++;
      end
    end
  end

  initial begin
    int w;
    int wsum;
    int oc;
    logic [7:0] t1_ops [8];
    checks = 0; errors = 0; out_count = 0;
    model_acc = ACC_INIT_TB;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
    negate = 1'b0; acc_src = 1'b0; acc_wr = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;

    // Reset state
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'(0));
    check_eq("rst_result", 32'(result), 32'(0));
    check_eq("rst_zero", 32'(zero), 32'(0));
    check_eq("rst_parity", 32'(parity), 32'(0));
    check_eq("rst_acc", 32'(acc), 32'(ACC_INIT_TB));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'(1));

    // Latency: accept at edge N, out_valid after edge N+1
    send(8'hA5, 8'h0F, 3'd5, 1'b0, 1'b0, 1'b0, w);
    @(negedge clk);
    check_eq("lat_n", 32'(out_valid), 32'(0));
    @(negedge clk);
    check_eq("lat_n1", 32'(out_valid), 32'(1));
    drain("lat_drain");

    // Test 1: all opcodes back-to-back, full throughput
    wsum = 0;
    oc = out_count;
    for (int i = 0; i < 8; i++) begin
      send(8'hF0, 8'h3C, 3'(i), 1'b0, 1'b0, 1'b0, w);
      wsum += w;
    end
    check_eq("t1_stalls", 32'(wsum), 32'(0));
    drain("t1_drain");
    check_eq("t1_count", 32'(out_count - oc), 32'(8));
    // Spot-check the model's expectations against the literal table
    t1_ops = '{8'h0F, 8'h30, 8'hCF, 8'hFC, 8'h03, 8'hCC, 8'h33, 8'hF0};
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e = model(8'hF0, 8'h3C, 3'(i), 1'b0);
      check_eq("t1_table", 32'(e.r), 32'(t1_ops[i]));
    end

    // Test 2: negate with AND
    send(8'h00, 8'hFF, 3'd1, 1'b1, 1'b0, 1'b0, w);
    send(8'h00, 8'hFF, 3'd1, 1'b0, 1'b0, 1'b0, w);
    drain("t2_drain");

    // Test 3: back-to-back accumulate
    send(8'h00, 8'h01, 3'd3, 1'b0, 1'b1, 1'b1, w);
    send(8'h00, 8'h02, 3'd3, 1'b0, 1'b1, 1'b1, w);
    send(8'h00, 8'h80, 3'd3, 1'b0, 1'b1, 1'b1, w);
    check_eq("t3_acc", 32'(acc), 32'(8'h83));
    drain("t3_drain");

    // Test 4: backpressure, two beats held, in_ready low
    out_ready = 1'b0;
    send(8'h11, 8'h22, 3'd3, 1'b0, 1'b0, 1'b0, w);
    send(8'h0F, 8'hF0, 3'd5, 1'b0, 1'b0, 1'b0, w);
    a = 8'hAA; b = 8'h0F; op = 3'd1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("t4_in_ready", 32'(in_ready), 32'(0));
      check_eq("t4_held", 32'(result), 32'(8'h33));
      check_eq("t4_out_valid", 32'(out_valid), 32'(1));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    oc = out_count;
    send(8'hAA, 8'h0F, 3'd1, 1'b0, 1'b0, 1'b0, w);
    send(8'hAA, 8'h55, 3'd4, 1'b0, 1'b0, 1'b0, w);
    drain("t4_drain");
    check_eq("t4_count", 32'(out_count - oc), 32'(4));

    // Test 5: acc_clr beats a simultaneous acc_wr; beat uses pre-clear acc
    send(8'h55, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1, w);
    check_eq("t5_acc55", 32'(acc), 32'(8'h55));
    acc_clr = 1'b1;
    send(8'hAA, 8'h00, 3'd7, 1'b0, 1'b1, 1'b1, w);
    acc_clr = 1'b0;
    check_eq("t5_acc_clr", 32'(acc), 32'(ACC_INIT_TB));
    drain("t5_drain");

    // Test 6: async reset with two beats in flight
    out_ready = 1'b0;
    send(8'h3C, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1, w);
    send(8'hC3, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1, w);
    check_eq("t6_acc_pre", 32'(acc), 32'(8'hC3));
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_out_valid", 32'(out_valid), 32'(0));
    check_eq("t6_acc", 32'(acc), 32'(ACC_INIT_TB));
    sb.delete();
    model_acc = ACC_INIT_TB;
    out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h0F, 8'h01, 3'd3, 1'b0, 1'b0, 1'b0, w);
    @(negedge clk);
    check_eq("t6_lat_n", 32'(out_valid), 32'(0));
    @(negedge clk);
    check_eq("t6_lat_n1", 32'(out_valid), 32'(1));
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
